quantum_timer: RTL

QUANTUM_TIMER -- requirements
Module: quantum_timer

---
 rtl/fpg8_pkg.sv | 19 +
 rtl/tick_divider.sv | 42 ++++
 rtl/quantum_timer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fpg8_pkg.sv
// fpg8_pkg: definitions shared across the fpg8 CPU slice.
//   WIDTH_DEFAULT - default data bus / quantum width
//   IDLE/RUN/EXPIRED - quantum timer state encodings
//   qt_state_e    - typed quantum timer state built on those encodings
package fpg8_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] EXPIRED = 2'd2;

    typedef enum logic [1:0] {
        StIdle    = IDLE,
        StRun     = RUN,
        StExpired = EXPIRED
    } qt_state_e;

endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running prescaler for the quantum timer.
//   clk   - system clock (rising edge)
//   reset - asynchronous, active-high reset
//   clr   - synchronous clear to 0 (wins over en)
//   en    - advance the prescaler this cycle
//   tick  - high in the cycle whose edge wraps the prescaler back to 0
module tick_divider #(
    parameter int unsigned PRESCALE_BITS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // A zero-bit prescaler still needs a 1-bit register; its max is 0 so it ticks every cycle.
    localparam int unsigned CntW = (PRESCALE_BITS == 0) ? 1 : PRESCALE_BITS;
    localparam logic [CntW-1:0] CntMax = CntW'((64'd1 << PRESCALE_BITS) - 64'd1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/quantum_timer.sv
// quantum_timer: user-mode time-slice timer with trap on expiry.
//   clk        - system clock (rising edge)
//   reset      - asynchronous, active-high reset
//   bus_in     - quantum value, captured on timer_in
//   timer_in   - load strobe from the timer-load instruction
//   privileged - kernel mode; freezes the quantum so kernel time is not charged
//   trap_ack   - control unit is in the timer-trap entry state
//   timeout    - registered quantum-expired flag
//   running    - registered, high while a quantum is being consumed
//   count_out  - registered remaining quantum
module quantum_timer
    import fpg8_pkg::*;
#(
    parameter int unsigned WIDTH         = WIDTH_DEFAULT,
    parameter int unsigned PRESCALE_BITS = 4,
    parameter int unsigned AUTO_RELOAD   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             timer_in,
    input  logic             privileged,
    input  logic             trap_ack,
    output logic             timeout,
    output logic             running,
    output logic [WIDTH-1:0] count_out
);

    qt_state_e        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             timeout_q, timeout_d;
    logic             running_q, running_d;

    logic tick;
    logic pre_en;
    logic pre_clr;

    // The prescaler only advances while user code runs; any load or non-RUN state zeroes it,
    // so every fresh quantum starts with a full prescale period.
    assign pre_en  = (state_q == StRun) && !privileged && !timer_in;
    assign pre_clr = timer_in || (state_q != StRun);

    tick_divider #(
        .PRESCALE_BITS(PRESCALE_BITS)
    ) u_tick_divider (
        .clk  (clk),
        .reset(reset),
        .clr  (pre_clr),
        .en   (pre_en),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        timeout_d = timeout_q;

        if (timer_in) begin
            // A load overrides everything, including a simultaneous trap_ack.
            count_d   = bus_in;
            reload_d  = bus_in;
            timeout_d = 1'b0;
            state_d   = (bus_in != '0) ? StRun : StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    count_d   = '0;
                    timeout_d = 1'b0;
                end
                StRun: begin
                    if (tick && (count_q != '0)) begin
                        count_d = count_q - WIDTH'(1);
                        if (count_q == WIDTH'(1)) begin
                            state_d   = StExpired;
                            timeout_d = 1'b1;
                        end
                    end
                end
                StExpired: begin
                    count_d   = '0;
                    timeout_d = 1'b1;
                    if (trap_ack) begin
                        timeout_d = 1'b0;
                        if ((AUTO_RELOAD != 0) && (reload_q != '0)) begin
                            count_d = reload_q;
                            state_d = StRun;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: begin
                    state_d   = StIdle;
                    count_d   = '0;
                    timeout_d = 1'b0;
                end
            endcase
        end

        running_d = (state_d == StRun);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            reload_q  <= '0;
            timeout_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            timeout_q <= timeout_d;
            running_q <= running_d;
        end
    end

    assign timeout   = timeout_q;
    assign running   = running_q;
    assign count_out = count_q;

endmodule
